// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit and the control unit that drives it.
package mult_div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MULT = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MULT   = 2'b01,
    ST_DIV    = 2'b10,
    ST_FINISH = 2'b11
  } state_e;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // 0x80000000 maps onto itself, which reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit writing HI/LO.
// Both datapaths share one accumulator/shift register pair, the step counter and the FSM.
module mult_div_unit #(
  parameter int WIDTH = mult_div_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);
  import mult_div_pkg::*;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  // acc_r: Booth accumulator / partial remainder; mq_r: multiplier / dividend-quotient
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mq_r;
  logic [WIDTH-1:0] mcand_r;
  logic             q1_r;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_rem_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;
  logic             div0_r;

  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic             div_fits_s;
  logic [WIDTH-1:0] hi_fin_s;
  logic [WIDTH-1:0] lo_fin_s;

  // One Booth add/subtract, done one bit wider so the most negative multiplicand cannot overflow.
  always_comb begin
    booth_sum_s = {acc_r[WIDTH-1], acc_r};
    case ({mq_r[0], q1_r})
      2'b01:   booth_sum_s = {acc_r[WIDTH-1], acc_r} + {mcand_r[WIDTH-1], mcand_r};
      2'b10:   booth_sum_s = {acc_r[WIDTH-1], acc_r} - {mcand_r[WIDTH-1], mcand_r};
      default: booth_sum_s = {acc_r[WIDTH-1], acc_r};
    endcase
  end

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  always_comb begin
    div_shift_s = {acc_r, mq_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mcand_r};
    div_fits_s  = ~div_diff_s[WIDTH];
    if (is_div_r) begin
      lo_fin_s = neg_q_r   ? twos_neg(mq_r)  : mq_r;
      hi_fin_s = neg_rem_r ? twos_neg(acc_r) : acc_r;
    end else begin
      lo_fin_s = mq_r;
      hi_fin_s = acc_r;
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      mq_r      <= {WIDTH{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      q1_r      <= 1'b0;
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      div0_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      div0_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          case (op_e'(op))
            OP_MULT: begin
              acc_r    <= {WIDTH{1'b0}};
              mq_r     <= b;
              mcand_r  <= a;
              q1_r     <= 1'b0;
              cnt_r    <= {CNT_W{1'b0}};
              is_div_r <= 1'b0;
              busy_r   <= 1'b1;
              state_r  <= ST_MULT;
            end
            OP_DIV: begin
              if (b == {WIDTH{1'b0}}) begin
                div0_r <= 1'b1;
              end else begin
                acc_r     <= {WIDTH{1'b0}};
                mq_r      <= magnitude(a);
                mcand_r   <= magnitude(b);
                neg_q_r   <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_rem_r <= a[WIDTH-1];
                cnt_r     <= {CNT_W{1'b0}};
                is_div_r  <= 1'b1;
                busy_r    <= 1'b1;
                state_r   <= ST_DIV;
              end
            end
            default: state_r <= ST_IDLE;
          endcase
        end
        ST_MULT: begin
          acc_r <= booth_sum_s[WIDTH:1];
          mq_r  <= {booth_sum_s[0], mq_r[WIDTH-1:1]};
          q1_r  <= mq_r[0];
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_STEP) begin
            state_r <= ST_FINISH;
          end
        end
        ST_DIV: begin
          if (div_fits_s) begin
            acc_r <= div_diff_s[WIDTH-1:0];
            mq_r  <= {mq_r[WIDTH-2:0], 1'b1};
          end else begin
            acc_r <= div_shift_s[WIDTH-1:0];
            mq_r  <= {mq_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_STEP) begin
            state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          hi_r    <= hi_fin_s;
          lo_r    <= lo_fin_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;
  assign div0 = div0_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: directed corner cases plus random signed mult/div against a 64-bit arithmetic model.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  int          n_checks;
  int          n_pass;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h0000_0001;
      3:       v = 32'h7FFF_FFFF;
      4:       v = $urandom_range(0, 20) - 10;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Called on a falling edge; drives the command, waits for its outcome and leaves op at NONE.
  // While busy, busy_op and random operands are driven to prove they are ignored.
  task automatic run_cmd(input logic [1:0] c_op, input logic [31:0] c_a, input logic [31:0] c_b,
                         input logic [1:0] busy_op);
    longint sa, sb, p, q, r;
    int     cyc;
    logic   seen;
    logic   busy_ok;
    op = c_op;
    a  = c_a;
    b  = c_b;
    sa = longint'($signed(c_a));
    sb = longint'($signed(c_b));
    if (c_op == 2'b10 && c_b == 32'd0) begin
      @(negedge clock);
      op = 2'b00;
      check("div0_pulse", {63'd0, div0}, 64'd1);
      check("div0_busy", {63'd0, busy}, 64'd0);
      check("div0_done", {63'd0, done}, 64'd0);
      @(negedge clock);
      check("div0_one_cycle", {63'd0, div0}, 64'd0);
      check("div0_hi_kept", {32'd0, hi}, {32'd0, exp_hi});
      check("div0_lo_kept", {32'd0, lo}, {32'd0, exp_lo});
    end else if (c_op == 2'b01 || c_op == 2'b10) begin
      if (c_op == 2'b01) begin
        p      = sa * sb;
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end else begin
        q      = sa / sb;
        r      = sa % sb;
        exp_hi = r[31:0];
        exp_lo = q[31:0];
      end
      seen    = 1'b0;
      busy_ok = 1'b1;
      cyc     = -1;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clock);
        op = busy_op;
        a  = $urandom;
        b  = $urandom;
        if (done) begin
          seen = 1'b1;
          cyc  = k;
        end else if (!busy) begin
          busy_ok = 1'b0;
        end
      end
      op = 2'b00;
      check("done_latency", 64'(cyc), 64'd33);
      check("busy_while_iterating", {63'd0, busy_ok}, 64'd1);
      check("busy_low_at_done", {63'd0, busy}, 64'd0);
      check("result_hi", {32'd0, hi}, {32'd0, exp_hi});
      check("result_lo", {32'd0, lo}, {32'd0, exp_lo});
    end else begin
      @(negedge clock);
      op = 2'b00;
      check("idle_op_busy", {63'd0, busy}, 64'd0);
      check("idle_op_hi", {32'd0, hi}, {32'd0, exp_hi});
    end
  endtask

  initial begin
    logic seen_done;
    n_checks = 0;
    n_pass   = 0;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;
    op       = 2'b00;
    a        = 32'd0;
    b        = 32'd0;
    reset    = 1'b1;

    // Reset values are visible before any clock edge.
    #2;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_div0", {63'd0, div0}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Directed examples.
    run_cmd(2'b01, 32'd7, 32'hFFFF_FFFD, 2'b00);
    run_cmd(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00);
    run_cmd(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
    run_cmd(2'b01, 32'h8000_0000, 32'h8000_0000, 2'b00);
    run_cmd(2'b01, 32'd12345, 32'hFFFF_0000, 2'b00);
    run_cmd(2'b10, 32'd5, 32'd0, 2'b00);
    run_cmd(2'b11, 32'd9, 32'd9, 2'b00);

    // Divide held during a multiply is ignored and not started once op is dropped after done.
    run_cmd(2'b01, 32'd7, 32'hFFFF_FFFD, 2'b10);
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      seen_done = seen_done | done | busy;
    end
    check("held_div_not_started", {63'd0, seen_done}, 64'd0);

    // Reset in the middle of a multiply aborts it.
    op = 2'b01;
    a  = 32'd1000;
    b  = 32'd1000;
    @(negedge clock);
    op = 2'b00;
    for (int k = 0; k < 14; k++) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("midop_reset_busy", {63'd0, busy}, 64'd0);
    check("midop_reset_hi", {32'd0, hi}, 64'd0);
    check("midop_reset_lo", {32'd0, lo}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      seen_done = seen_done | done;
    end
    check("no_done_after_abort", {63'd0, seen_done}, 64'd0);
    run_cmd(2'b01, 32'h0001_0000, 32'h0001_0000, 2'b00);

    // Random back-to-back commands.
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] rop;
      logic [31:0] ra;
      logic [31:0] rb;
      case ($urandom_range(0, 19))
        0:       rop = 2'b00;
        1:       rop = 2'b11;
        default: rop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      endcase
      ra = pick_operand();
      rb = ($urandom_range(0, 24) == 0) ? 32'd0 : pick_operand();
      run_cmd(rop, ra, rb, 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is required to work.
REQ-002 clock  input  1  system clock, all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 op  input  2  command from control unit: 00 none, 01 signed mult, 10 signed div, 11 reserved.
REQ-005 a  input  WIDTH  operand A (rs): multiplicand or dividend.
REQ-006 b  input  WIDTH  operand B (rt): multiplier or divisor.
REQ-007 hi  output  WIDTH  HI register: product[63:32] or remainder.
REQ-008 lo  output  WIDTH  LO register: product[31:0] or quotient.
REQ-009 busy  output  1  high while an operation iterates.
REQ-010 done  output  1  one-cycle pulse when hi/lo were just updated.
REQ-011 div0  output  1  one-cycle pulse on divide by zero.

Function
REQ-012 The block SHALL implement states IDLE, MULT, DIV, FINISH.
REQ-013 In IDLE, op and both operands SHALL be sampled at each rising edge; op 00 or 11 leaves the block in IDLE.
REQ-014 op=01 sampled in IDLE SHALL latch a and b, clear the 6-bit iteration counter and enter MULT.
REQ-015 MULT SHALL perform one radix-2 Booth step per cycle over a 65-bit {acc, multiplier, q-1} register for exactly 32 cycles.
REQ-016 op=10 with b!=0 sampled in IDLE SHALL latch |a|, |b| and both signs, and enter DIV.
REQ-017 DIV SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles.
REQ-018 After the 32nd step, the block SHALL enter FINISH. In FINISH it SHALL write hi/lo, assert done for that one cycle, and return to IDLE.
REQ-019 Latency: command sampled at edge t0 -> busy high from t0 through t0+32 -> hi/lo valid and done high after edge t0+33.
REQ-020 Division SHALL truncate toward zero; the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
REQ-021 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, with no flag raised.
REQ-022 op=10 with b==0 sampled in IDLE SHALL pulse div0 for one cycle after that edge; hi/lo stay unchanged; busy and done stay low; the block stays in IDLE.
REQ-023 op and operand changes while busy SHALL be ignored; a command is accepted again in the cycle after done.
REQ-024 hi/lo SHALL hold their values at all times except in FINISH or on reset.
REQ-025 Multiplication SHALL be signed 32x32->64 with no overflow indication.

Reset
REQ-026 Reset SHALL force IDLE, counter 0, hi=0, lo=0, busy=0, done=0, div0=0, independent of the clock.
REQ-027 Reset asserted mid-operation SHALL abort the operation; no done pulse is produced, and the next command after reset release SHALL be accepted normally.

Structure
REQ-028 The op encodings (NONE/MULT/DIV), the state encoding and WIDTH SHALL live in shared package mult_div_pkg, which the control unit also uses.
REQ-029 The block SHALL be a single module with no sub-modules; Booth and restoring datapaths share the counter and FSM.

Verification
REQ-030 op=01, a=7, b=-3 -> done after 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 op=10, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; op=10, a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-032 op=10, a=5, b=0 -> div0 high exactly one cycle; busy never high; hi/lo retain their previous product.
REQ-033 op=01 issued, then op=10 held during cycles t0+1..t0+32 -> only the multiply result appears, one done pulse; the divide is accepted only if op=10 is still present after done.
REQ-034 reset pulsed at cycle t0+15 of a multiply -> hi=lo=0, busy=0, no done; a new op=01, a=0x10000, b=0x10000 -> hi=1, lo=0.
REQ-035 Random signed operand pairs (>=1000) compared against a 64-bit reference multiply/divide model; back-to-back commands issued in the cycle after done.
